// File: rtl/bsg_fifo_rolly_pkg.sv
// Shared types for the rolly FIFO replay reader.
//  rr_state_e    : reader FSM states (send / wait for response / commit / rewind)
//  rr_resp_s     : link response as seen by the reader {v, ack}
//  rr_cnt_width  : counter width able to hold 0..max_val, never narrower than 1 bit
package bsg_fifo_rolly_pkg;

  typedef enum logic [1:0] {
    e_rr_send   = 2'd0,
    e_rr_wait   = 2'd1,
    e_rr_commit = 2'd2,
    e_rr_rewind = 2'd3
  } rr_state_e;

  typedef struct packed {
    logic v;
    logic ack;
  } rr_resp_s;

  function automatic int rr_cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bsg_fifo_rolly_replay_reader_if.sv
// Downstream link between the replay reader and the consumer.
//  v, data, last : beat stream from reader (master) to link (slave)
//  ready         : link accepts the current beat
//  resp_v        : one-cycle response pulse, resp_ack qualifies it (1=ack, 0=nack)
interface bsg_fifo_rolly_replay_reader_if #(
  parameter int width_p = 32
);
  logic               v;
  logic [width_p-1:0] data;
  logic               last;
  logic               ready;
  logic               resp_v;
  logic               resp_ack;

  modport master (output v, data, last, input ready, resp_v, resp_ack);
  modport slave  (input v, data, last, output ready, resp_v, resp_ack);
endinterface

// File: rtl/bsg_rolly_timeout_ctr.sv
// Saturating response-timeout counter.
//  clk_i, reset_ni : clock, async active-low reset
//  clear_i         : return count to zero (has priority over en_i)
//  en_i            : count one cycle
//  hit_o           : count has reached timeout_p-1; the counter parks there
module bsg_rolly_timeout_ctr
  import bsg_fifo_rolly_pkg::*;
#(
  parameter int timeout_p = 64
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic hit_o
);
  localparam int                 cnt_w_lp = rr_cnt_width(timeout_p);
  localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(timeout_p - 1);

  logic [cnt_w_lp-1:0] count;

  // count up while enabled, parking at the hit value so it never wraps
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (en_i && (count != last_lp)) begin
      count <= count + cnt_w_lp'(1);
    end
  end

  assign hit_o = (count == last_lp);
endmodule

// File: rtl/bsg_fifo_rolly_replay_reader.sv
// Read-side consumer of the rolly FIFO: streams one packet to the link, waits
// for ack/nack, then checkpoints (forward) or rewinds and resends. After
// max_retries_p failed resends the packet is forwarded past and dropped.
//  clk_i, reset_ni         : clock, async active-low reset
//  fifo_v_i/data_i/last_i  : FIFO head beat
//  fifo_deq/rewind/forward : tracker read controls; fifo_incr_o is always 0
//  link (master)           : beat stream out, ready and response in
//  retry_cnt_o             : resends spent on the current packet
//  drop_o                  : one-cycle pulse when a packet is abandoned
//  oversize_o              : sticky, a packet ran past 2**lg_size_p beats
module bsg_fifo_rolly_replay_reader
  import bsg_fifo_rolly_pkg::*;
#(
  parameter int  width_p       = 32,
  parameter int  lg_size_p     = 4,
  parameter int  timeout_p     = 64,
  parameter int  max_retries_p = 3,
  localparam int retry_w_lp    = rr_cnt_width(max_retries_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  fifo_v_i,
  input  logic [width_p-1:0]    fifo_data_i,
  input  logic                  fifo_last_i,
  output logic                  fifo_deq_o,
  output logic                  fifo_rewind_o,
  output logic                  fifo_forward_o,
  output logic                  fifo_incr_o,
  bsg_fifo_rolly_replay_reader_if.master link,
  output logic [retry_w_lp-1:0] retry_cnt_o,
  output logic                  drop_o,
  output logic                  oversize_o
);
  localparam int                    beat_w_lp    = lg_size_p + 1;
  localparam logic [beat_w_lp-1:0]  pkt_max_lp   = beat_w_lp'(2 ** lg_size_p);
  localparam logic [beat_w_lp-1:0]  beat_sat_lp  = '1;
  localparam logic [retry_w_lp-1:0] retry_max_lp = retry_w_lp'(max_retries_p);

  rr_state_e             state, state_n;
  logic [retry_w_lp-1:0] retry_cnt, retry_cnt_n;
  logic [beat_w_lp-1:0]  beat_cnt, beat_cnt_n;
  logic                  oversize, oversize_n;
  logic                  v, deq, rewind, forward, drop;
  logic                  tmo_clear, tmo_en, tmo_hit;
  rr_resp_s              resp;

  assign resp = {link.resp_v, link.resp_ack};

  bsg_rolly_timeout_ctr #(.timeout_p(timeout_p)) timeout_ctr (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clear_i (tmo_clear),
    .en_i    (tmo_en),
    .hit_o   (tmo_hit)
  );

  // state and counter registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= e_rr_send;
      retry_cnt <= '0;
      beat_cnt  <= '0;
      oversize  <= 1'b0;
    end else begin
      state     <= state_n;
      retry_cnt <= retry_cnt_n;
      beat_cnt  <= beat_cnt_n;
      oversize  <= oversize_n;
    end
  end

  // next-state, counter updates and read-control decode
  always_comb begin
    state_n     = state;
    retry_cnt_n = retry_cnt;
    beat_cnt_n  = beat_cnt;
    oversize_n  = oversize;
    v           = 1'b0;
    deq         = 1'b0;
    rewind      = 1'b0;
    forward     = 1'b0;
    drop        = 1'b0;
    tmo_clear   = 1'b1;
    tmo_en      = 1'b0;
    case (state)
      e_rr_send: begin
        v   = fifo_v_i;
        deq = fifo_v_i & link.ready;
        if (deq) begin
          // one more beat than the FIFO can hold means the writer broke framing
          if (beat_cnt == pkt_max_lp) begin
            oversize_n = 1'b1;
          end else begin
            oversize_n = oversize;
          end
          if (fifo_last_i) begin
            beat_cnt_n = '0;
            state_n    = e_rr_wait;
          end else if (beat_cnt != beat_sat_lp) begin
            beat_cnt_n = beat_cnt + beat_w_lp'(1);
          end else begin
            beat_cnt_n = beat_cnt;
          end
        end else begin
          beat_cnt_n = beat_cnt;
        end
      end
      e_rr_wait: begin
        tmo_clear = 1'b0;
        tmo_en    = 1'b1;
        // an explicit response beats a coincident timeout
        if (resp.v) begin
          state_n = resp.ack ? e_rr_commit : e_rr_rewind;
        end else if (tmo_hit) begin
          state_n = e_rr_rewind;
        end else begin
          state_n = e_rr_wait;
        end
      end
      e_rr_commit: begin
        forward     = 1'b1;
        retry_cnt_n = '0;
        state_n     = e_rr_send;
      end
      e_rr_rewind: begin
        if (retry_cnt < retry_max_lp) begin
          rewind      = 1'b1;
          retry_cnt_n = retry_cnt + retry_w_lp'(1);
        end else begin
          // out of retries: step the checkpoint past the packet and give up
          forward     = 1'b1;
          drop        = 1'b1;
          retry_cnt_n = '0;
        end
        state_n = e_rr_send;
      end
      default: begin
        state_n = e_rr_send;
      end
    endcase
  end

  // the FIFO head can be valid while reset is held, so gate the stream with it
  assign link.v         = v & reset_ni;
  assign link.data      = fifo_data_i;
  assign link.last      = fifo_last_i;
  assign fifo_deq_o     = deq & reset_ni;
  assign fifo_rewind_o  = rewind;
  assign fifo_forward_o = forward;
  assign fifo_incr_o    = 1'b0;
  assign drop_o         = drop;
  assign retry_cnt_o    = retry_cnt;
  assign oversize_o     = oversize;
endmodule
